// File: rtl/shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shifter_pkg                                                     |
// | Purpose  : Shared geometry and state encoding for the shift/mux array      |
// |            and the sequencer that drives it.                               |
// | Contents : LANE_W, NLANES, DATA_W, state_e {IDLE, RUN, DONE}               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package shifter_pkg;

  localparam int LANE_W = 4;
  localparam int NLANES = 4;
  localparam int DATA_W = LANE_W * NLANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_sequencer_if                                              |
// | Purpose  : Command and result handshakes of the shift sequencer.           |
// | Signals  : cmd_valid/cmd_ready, cmd_data[16], cmd_dir, cmd_steps[STEP_W],  |
// |            cmd_fill[4]; res_valid/res_ready, res_data[16]                  |
// | Modports : master - command producer / result consumer                     |
// |            slave  - the sequencer                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface shift_sequencer_if #(
  parameter int STEP_W = 4
) ();
  import shifter_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DATA_W-1:0]    cmd_data;
  logic                 cmd_dir;
  logic [STEP_W-1:0]    cmd_steps;
  logic [LANE_W-1:0]    cmd_fill;

  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_W-1:0]    res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_steps, cmd_fill, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_steps, cmd_fill, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface : shift_sequencer_if
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_sequencer                                                 |
// | Purpose  : Holds the four lane registers feeding the external shift/mux    |
// |            array, loads them from a command, clocks the array outputs back |
// |            in for the requested number of steps and returns the result.    |
// | Ports    : clk, rst (sync, active high)                                    |
// |            bus          - command / result handshakes (slave modport)      |
// |            sh_s         - array select (registered cmd_dir)                |
// |            sh_a0..sh_a3 - lane registers R0..R3                            |
// |            sh_ir, sh_il - registered fill value                            |
// |            sh_h0..sh_h3 - array outputs, sampled only while running        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  shift_sequencer_if.slave       bus,
  output logic                   sh_s,
  output logic [LANE_W-1:0]      sh_a0,
  output logic [LANE_W-1:0]      sh_a1,
  output logic [LANE_W-1:0]      sh_a2,
  output logic [LANE_W-1:0]      sh_a3,
  output logic [LANE_W-1:0]      sh_ir,
  output logic [LANE_W-1:0]      sh_il,
  input  wire logic [LANE_W-1:0] sh_h0,
  input  wire logic [LANE_W-1:0] sh_h1,
  input  wire logic [LANE_W-1:0] sh_h2,
  input  wire logic [LANE_W-1:0] sh_h3
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [STEP_W-1:0] C_CNT_LAST = STEP_W'(1);

  logic [1:0]                          r_state;
  logic [NLANES-1:0][LANE_W-1:0]       r_lanes;
  logic                                r_dir;
  logic [LANE_W-1:0]                   r_fill;
  logic [STEP_W-1:0]                   r_cnt;
  logic [NLANES-1:0][LANE_W-1:0]       w_h;

  assign w_h = {sh_h3, sh_h2, sh_h1, sh_h0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lanes <= '0;
      r_dir   <= 1'b0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_lanes <= bus.cmd_data;
            r_dir   <= bus.cmd_dir;
            r_fill  <= bus.cmd_fill;
            r_cnt   <= bus.cmd_steps;
            r_state <= (bus.cmd_steps == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          r_lanes <= w_h;
          r_cnt   <= r_cnt - C_CNT_LAST;
          // Leaving on cnt==1 means the counter bottoms out at zero and never wraps.
          if (r_cnt == C_CNT_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from state; only IDLE accepts commands.
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.res_data  = r_lanes;

  // Array drive comes from registers only, so the array loop is broken by flops.
  assign sh_s  = r_dir;
  assign sh_ir = r_fill;
  assign sh_il = r_fill;
  assign sh_a0 = r_lanes[0];
  assign sh_a1 = r_lanes[1];
  assign sh_a2 = r_lanes[2];
  assign sh_a3 = r_lanes[3];

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_sequencer                                              |
// | Purpose  : Self-checking bench for shift_sequencer with a stand-in for the |
// |            shift/mux array and a lane-list reference model.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       sh_s;
  logic [3:0] sh_a0, sh_a1, sh_a2, sh_a3, sh_ir, sh_il;
  logic [3:0] sh_h0, sh_h1, sh_h2, sh_h3;
  logic [15:0] lanes;
  logic [15:0] first_lanes;

  int n_checks = 0;
  int n_errors = 0;

  shift_sequencer_if #(.STEP_W(4)) bus ();

  shift_sequencer #(.STEP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .sh_s  (sh_s),
    .sh_a0 (sh_a0),
    .sh_a1 (sh_a1),
    .sh_a2 (sh_a2),
    .sh_a3 (sh_a3),
    .sh_ir (sh_ir),
    .sh_il (sh_il),
    .sh_h0 (sh_h0),
    .sh_h1 (sh_h1),
    .sh_h2 (sh_h2),
    .sh_h3 (sh_h3)
  );

  assign lanes = {sh_a3, sh_a2, sh_a1, sh_a0};

  // Stand-in for the shift/mux array: select 0 moves lanes upward with the
  // fill entering lane 0, select 1 moves them downward with the fill entering lane 3.
  always_comb begin
    if (!sh_s) begin
      sh_h0 = {1'b0, sh_ir[3:1]};
      sh_h1 = sh_a0;
      sh_h2 = sh_a1;
      sh_h3 = {sh_a2[2:0], 1'b0};
    end else begin
      sh_h3 = {sh_il[2:0], 1'b0};
      sh_h2 = sh_a3;
      sh_h1 = sh_a2;
      sh_h0 = {1'b0, sh_a1[3:1]};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of lane values stepped with integer arithmetic.
  function automatic logic [15:0] ref_result(input logic [15:0] data, input logic dir,
                                             input logic [3:0] fill, input int steps);
    int lane[4];
    int nx[4];
    for (int i = 0; i < 4; i++) lane[i] = (int'(data) >> (4 * i)) % 16;
    for (int s = 0; s < steps; s++) begin
      if (!dir) begin
        nx[0] = int'(fill) / 2;
        nx[1] = lane[0];
        nx[2] = lane[1];
        nx[3] = (lane[2] * 2) % 16;
      end else begin
        nx[3] = (int'(fill) * 2) % 16;
        nx[2] = lane[3];
        nx[1] = lane[2];
        nx[0] = lane[1] / 2;
      end
      lane = nx;
    end
    return 16'(lane[3] * 4096 + lane[2] * 256 + lane[1] * 16 + lane[0]);
  endfunction

  task automatic run_cmd(input string tag, input logic [15:0] data, input logic dir,
                         input logic [3:0] fill, input logic [3:0] steps,
                         input int hold, input logic [15:0] exp);
    int waited;
    int lat;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = data;
    bus.cmd_dir   = dir;
    bus.cmd_fill  = fill;
    bus.cmd_steps = steps;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'($urandom);
    bus.cmd_dir   = 1'($urandom);
    bus.cmd_fill  = 4'($urandom);
    bus.cmd_steps = 4'($urandom);
    lat = 0;
    first_lanes = lanes;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) first_lanes = lanes;
    end
    check({tag, "_latency"}, 32'(lat), 32'(steps));
    if (bus.res_valid !== 1'b1) return;
    check({tag, "_data"}, 32'(bus.res_data), 32'(exp));
    check({tag, "_busy"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_sh"}, {26'd0, sh_s, sh_ir, sh_il}, {26'd0, dir, fill, fill});
    bus.res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = (i == hold / 2);
      bus.cmd_data  = ~data;
      bus.cmd_steps = 4'd0;
      tick();
      check({tag, "_hold_data"}, {15'd0, bus.res_valid, bus.res_data}, {15'd0, 1'b1, exp});
      check({tag, "_hold_busy"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_ret"}, {30'd0, bus.res_valid, bus.cmd_ready}, {30'd0, 1'b0, 1'b1});
    check({tag, "_kept"}, 32'(lanes), 32'(exp));
  endtask

  initial begin
    logic [15:0] d;
    logic        dr;
    logic [3:0]  f;
    logic [3:0]  st;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_fill  = '0;
    bus.cmd_steps = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_flags", {30'd0, bus.cmd_ready, bus.res_valid}, {30'd0, 1'b1, 1'b0});
    check("rst_data", 32'(bus.res_data), 32'd0);
    check("rst_sh", {3'd0, sh_s, lanes, sh_ir, sh_il}, 32'd0);

    run_cmd("step1_dir0", 16'h8421, 1'b0, 4'd3, 4'd1, 0, 16'h8211);
    run_cmd("step1_dir1", 16'h8421, 1'b1, 4'd3, 4'd1, 0, 16'h6841);
    run_cmd("step2_dir0", 16'h8421, 1'b0, 4'd0, 4'd2, 0, 16'h4100);
    check("step2_mid", 32'(first_lanes), 32'h8210);
    run_cmd("zero_steps", 16'hBEEF, 1'b0, 4'd5, 4'd0, 0, 16'hBEEF);
    run_cmd("backpress", 16'h1357, 1'b1, 4'd9, 4'd3, 5, ref_result(16'h1357, 1'b1, 4'd9, 3));

    // Reset in the fourth RUN cycle, with a command offered on the same edge.
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'h1234;
    bus.cmd_dir   = 1'b0;
    bus.cmd_fill  = 4'd7;
    bus.cmd_steps = 4'd15;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_busy", {30'd0, bus.cmd_ready, bus.res_valid}, 32'd0);
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'hFFFF;
    bus.cmd_steps = 4'd0;
    tick();
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    check("midrst_flags", {30'd0, bus.cmd_ready, bus.res_valid}, {30'd0, 1'b1, 1'b0});
    check("midrst_lanes", {11'd0, sh_s, lanes, 4'(sh_ir)}, 32'd0);
    tick();
    check("midrst_noacc", {30'd0, bus.cmd_ready, bus.res_valid}, {30'd0, 1'b1, 1'b0});

    for (int k = 0; k < 20; k++) begin
      d  = 16'($urandom);
      dr = 1'($urandom);
      f  = 4'($urandom);
      st = 4'($urandom_range(0, 15));
      run_cmd("rand", d, dr, f, st, int'($urandom_range(0, 2)), ref_result(d, dr, f, int'(st)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_shift_sequencer
`default_nettype wire
